rr_mux_packet_scheduler: RTL
============================

Name: rr_mux_packet_scheduler

Overview:
- Sequential front-end for the 4-input, 4-bit combinational data mux (mux_4_1).
- Arbitrates four valid/ready source channels round-robin and drives the mux select.
- Captures the mux output into a one-entry registered output stage with valid/ready.
- Packet mode: a granted channel keeps the mux until its last beat is accepted.

Parameters:
- W, 4, data width; must match mux data width.
- PKT_MODE, 1, 1 = hold grant until in_last beat accepted; 0 = re-arbitrate every beat.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  4  per-channel beat valid; bit i = channel i.
- in_last  input  4  per-channel last-beat-of-packet flag; sampled only with in_valid.
- in_ready  output  4  per-channel accept; at most one bit high (one-hot or zero).
- sel  output  2  select to mux_4_1; index of granted channel.
- mux_y  input  W  mux_4_1 output, combinational function of sel.
- out_data  output  W  registered beat.
- out_ch  output  2  channel index of out_data.
- out_last  output  1  registered in_last of the beat.
- out_valid  output  1  out_data/out_ch/out_last valid.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_ch=0, out_last=0, ptr=3, state=IDLE, lock_ch=0, sel=3.
- Clock/reset: one clock, clk; reset is asynchronous and active-high on rst. Assertion clears all state immediately. Deassertion is synchronous to clk.
- Slot free: can_load = !out_valid | out_ready.
- IDLE state:
  - Winner = first set in_valid bit scanning ptr+1, ptr+2, ptr+3, ptr (mod 4).
  - sel = winner if any in_valid is set; otherwise sel = ptr (held stable, no toggling).
- LOCKED state: sel = lock_ch. Only in_valid[lock_ch] is considered; other requests wait.
- in_ready[sel] = can_load & in_valid[sel] & (a winner exists, or state is LOCKED). All other in_ready bits are 0.
- Accept (in_ready[sel] & in_valid[sel]) updates on the next edge:
  - out_data<=mux_y, out_ch<=sel, out_last<=in_last[sel], out_valid<=1.
  - ptr<=sel.
- out_ready & out_valid with no accept in the same cycle: out_valid<=0 next edge.
- Drain and load in the same cycle: out_valid stays 1 and new data replaces old. Full throughput of 1 beat/cycle.
- Latency: source beat appears on out_data exactly 1 cycle after acceptance.
- FSM transitions (PKT_MODE=1):
  - IDLE to LOCKED: on accept with in_last[sel]=0; lock_ch<=sel.
  - LOCKED to IDLE: on accept with in_last[lock_ch]=1.
  - Accept with in_last=1 while IDLE (single-beat packet): stay IDLE.
- PKT_MODE=0: FSM stays IDLE; in_last is only forwarded to out_last.
- Backpressure: out_valid=1 and out_ready=0 gives in_ready=0 on all channels. sel is held and out_* are held stable.
- LOCKED with in_valid[lock_ch]=0 (bubble): no accept, lock held, other channels still blocked.
- Wrap-around: ptr=3 with next requester ch0 gives grant to ch0.
- Fairness: with all four channels continuously valid and single-beat packets, grant order is 0,1,2,3,0,...
- Reset mid-packet: lock dropped and pending out beat discarded. After release, arbitration restarts with ch0 highest priority.

Test Plan:
- Reset then in_valid=4'b1111, all in_last=1, out_ready=1: expect sel sequence 0,1,2,3,0. out_ch lags sel by 1 cycle. With d0..d3=4'h1,2,3,4, out_data sequence is 1,2,3,4.
- Packet lock: ch2 sends 3 beats (last on beat 3) while ch1 is continuously valid. Expect in_ready[1]=0 until the edge accepting ch2's last beat, then sel=3 if valid, else ch1 next. out_last=1 only on beat 3.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1: out_data/out_ch stable, in_ready=4'b0000. Release: next beat loads in the same cycle the old one drains, with no bubble.
- Idle: in_valid=0 for 5 cycles after grant to ch1: sel holds 1, out_valid falls 1 cycle after drain.
- Async reset asserted mid-packet between edges: out_valid=0 immediately. After release with only ch3 valid, sel=3 and ch3's beat is accepted.
- PKT_MODE=0 with ch0 and ch2 streaming and in_last=0: grants alternate 0,2,0,2.

Source files
------------

// File: rtl/rr_mux_packet_scheduler.sv
// Round-robin front-end for a 4:1 data mux: picks a source channel, drives the
// mux select, and registers the selected beat into a one-entry valid/ready stage.
module rr_mux_packet_scheduler #(
  parameter int W        = 4,
  parameter bit PKT_MODE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   in_valid,
  input  logic [3:0]   in_last,
  output logic [3:0]   in_ready,
  output logic [1:0]   sel,
  input  logic [W-1:0] mux_y,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_ch,
  output logic         out_last,
  output logic         out_valid,
  input  logic         out_ready
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t     state, state_nxt;
  logic [1:0] ptr, lock_ch, winner, idx;
  logic       win_any, can_load, grant_ok, accept;

  // Scan starts just past the last granted channel so the previous winner
  // drops to lowest priority.
  always_comb begin
    winner  = ptr;
    win_any = 1'b0;
    idx     = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (!win_any && in_valid[idx]) begin
        winner  = idx;
        win_any = 1'b1;
      end
    end
  end

  assign sel      = (state == LOCKED) ? lock_ch : winner;
  assign can_load = !out_valid || out_ready;
  assign grant_ok = win_any || (state == LOCKED);

  for (genvar i = 0; i < 4; i++) begin : g_rdy
    assign in_ready[i] = (sel == 2'(i)) && can_load && in_valid[i] && grant_ok;
  end

  assign accept = |in_ready;

  always_comb begin
    state_nxt = state;
    if (PKT_MODE && accept) begin
      case (state)
        IDLE:    if (!in_last[sel])    state_nxt = LOCKED;
        LOCKED:  if (in_last[lock_ch]) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      lock_ch <= 2'd0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == LOCKED) lock_ch <= sel;
    end
  end

  // Output slot: a load in the same cycle as a drain keeps out_valid high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= 2'd3;
      out_data  <= '0;
      out_ch    <= 2'd0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (accept) begin
      ptr       <= sel;
      out_data  <= mux_y;
      out_ch    <= sel;
      out_last  <= in_last[sel];
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
